// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Bundles the WB request, LLU result handshake, scoreboard
//               set/status and register-file write port of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;
  // WB stage
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  // LLU result port
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_addr;
  logic [31:0] llu_data;
  // Pending-write scoreboard
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic [31:0] pending;
  logic        waw_err;
  // Register file write port
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  // Writers / register file side
  modport master (
    output wb_we, wb_addr, wb_data, llu_valid, llu_addr, llu_data,
           sb_set, sb_set_addr,
    input  wb_stall, llu_ready, pending, waw_err, rf_we, rf_addr, rf_data
  );

  // Arbiter side
  modport slave (
    input  wb_we, wb_addr, wb_data, llu_valid, llu_addr, llu_data,
           sb_set, sb_set_addr,
    output wb_stall, llu_ready, pending, waw_err, rf_we, rf_addr, rf_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register-file write port between the WB stage
//               (priority) and a FIFO-buffered long-latency unit, keeps a
//               pending-write scoreboard and forces a WB stall when the LLU
//               FIFO head has been starved for STARVE_LIMIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  // FIFO storage (contents need no reset; pointers define validity)
  logic [4:0]  fifo_addr_q [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];

  // Extra MSB on each pointer distinguishes full from empty
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      pending_q, pending_d;
  logic             waw_err_q, waw_err_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;

  logic        empty;
  logic        full;
  logic        stall;
  logic        enq;
  logic        wb_write;
  logic        drain;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  // Arbitration, FIFO bookkeeping and scoreboard next-state
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    stall     = (wait_cnt_q == STARVE_MAX);
    head_addr = fifo_addr_q[rd_ptr_q[ADDR_W-1:0]];
    head_data = fifo_data_q[rd_ptr_q[ADDR_W-1:0]];

    // r0 results are still handshaken so the LLU never blocks on them
    enq      = bus.llu_valid && rst && !full && (bus.llu_addr != 5'd0);
    // A stalled WB is ignored outright; r0 writes never claim the port
    wb_write = !stall && bus.wb_we && (bus.wb_addr != 5'd0);
    drain    = !empty && !wb_write;

    wr_ptr_d = enq   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = drain ? rd_ptr_q + 1'b1 : rd_ptr_q;

    if (empty || drain)
      wait_cnt_d = '0;
    else if (wait_cnt_q != STARVE_MAX)
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    else
      wait_cnt_d = wait_cnt_q;

    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (drain) begin
      rf_we_d   = 1'b1;
      rf_addr_d = head_addr;
      rf_data_d = head_data;
    end else if (wb_write) begin
      rf_we_d   = 1'b1;
      rf_addr_d = bus.wb_addr;
      rf_data_d = bus.wb_data;
    end

    // Clear before set so a same-cycle issue to the drained register wins
    pending_d = pending_q;
    if (drain)
      pending_d[head_addr] = 1'b0;
    if (bus.sb_set && (bus.sb_set_addr != 5'd0))
      pending_d[bus.sb_set_addr] = 1'b1;

    waw_err_d = waw_err_q || (wb_write && pending_q[bus.wb_addr]);
  end

  // FIFO storage write on enqueue
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q[ADDR_W-1:0]] <= bus.llu_addr;
      fifo_data_q[wr_ptr_q[ADDR_W-1:0]] <= bus.llu_data;
    end
  end

  // Control state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wait_cnt_q <= '0;
      pending_q  <= '0;
      waw_err_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
      waw_err_q  <= waw_err_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign bus.llu_ready = rst && !full;
  assign bus.wb_stall  = stall;
  assign bus.pending   = pending_q;
  assign bus.waw_err   = waw_err_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_data   = rf_data_q;

endmodule
`default_nettype wire
